// File: rtl/ahb_slave_arbiter_mm_pkg.sv
// Shared types and constants for the per-slave AHB arbiter.
package AHB_package;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_type;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_type;

    // Encoding 2'b11 is not listed and falls back to FIXED in the selector.
    typedef enum logic [1:0] {
        FIXED = 2'b00,
        RR    = 2'b01,
        DYN   = 2'b10
    } arb_mode_type;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_type;

    // Counter value of the final beat for each fixed-length burst size.
    localparam logic [7:0] BEATS_4  = 8'd3;
    localparam logic [7:0] BEATS_8  = 8'd7;
    localparam logic [7:0] BEATS_16 = 8'd15;

endpackage

// File: rtl/ahb_slave_arbiter_mm_select.sv
// Combinational winner selection: fixed, round-robin or dynamic priority.
module ahb_arb_select
    import AHB_package::*;
#(
    parameter int MASTER_NUM = 4,
    parameter int PRIOR_BIT  = 2,
    localparam int IW        = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0]                i_req,
    input  logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] i_prior,
    input  logic [1:0]                           i_mode,
    input  logic [IW-1:0]                        i_rr_ptr,
    output logic [MASTER_NUM-1:0]                o_win,
    output logic                                 o_valid
);

    logic [IW-1:0]        w_sel;
    logic [PRIOR_BIT-1:0] w_best;
    logic                 w_found;

    // Pick one requester index; later loop iterations overwrite earlier ones,
    // so each loop runs in the order that leaves the preferred master last.
    always_comb begin
        w_sel   = '0;
        w_best  = '0;
        w_found = 1'b0;
        case (arb_mode_type'(i_mode))
            RR: begin
                // Scan from rr_ptr+N down to rr_ptr+1 so the nearest one wins.
                for (int k = MASTER_NUM; k >= 1; k--) begin
                    if (i_req[(int'(i_rr_ptr) + k) % MASTER_NUM])
                        w_sel = IW'((int'(i_rr_ptr) + k) % MASTER_NUM);
                end
            end
            DYN: begin
                // Strict greater-than keeps the lowest index on a tie.
                for (int i = 0; i < MASTER_NUM; i++) begin
                    if (i_req[i] && (!w_found || i_prior[i] > w_best)) begin
                        w_sel   = IW'(i);
                        w_best  = i_prior[i];
                        w_found = 1'b1;
                    end
                end
            end
            default: begin
                for (int i = MASTER_NUM - 1; i >= 0; i--) begin
                    if (i_req[i]) w_sel = IW'(i);
                end
            end
        endcase
    end

    // Convert the chosen index to a one-hot vector, empty when nobody asks.
    always_comb begin
        o_valid = |i_req;
        o_win   = '0;
        o_win[w_sel] = o_valid;
    end

endmodule

// File: rtl/ahb_slave_arbiter_mm.sv
// Per-slave AHB arbiter: owner FSM, burst beat counter and round-robin pointer.
module ahb_slave_arbiter_mm
    import AHB_package::*;
#(
    parameter int MASTER_NUM     = 4,
    parameter int PRIOR_BIT      = 2,
    parameter int MAX_INCR_BEATS = 16,
    localparam int IW            = $clog2(MASTER_NUM),
    localparam int CW            = $clog2(MAX_INCR_BEATS)
) (
    input  logic                                 hclk,
    input  logic                                 hreset_n,
    input  logic [MASTER_NUM-1:0]                hreq,
    input  logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] hprior,
    input  logic [1:0]                           arb_mode,
    input  hburst_type                           hburst,
    input  logic [1:0]                           htrans,
    input  logic                                 hwait,
    output logic [MASTER_NUM-1:0]                hgrant,
    output logic                                 hsel,
    output logic [IW-1:0]                        hmaster,
    output logic                                 hlast
);

    arb_state_type         r_state;
    arb_state_type         w_state_nxt;
    logic [MASTER_NUM-1:0] r_grant;
    logic [IW-1:0]         r_owner;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_rr_ptr;

    logic [MASTER_NUM-1:0] w_win;
    logic                  w_win_vld;
    logic [IW-1:0]         w_win_idx;
    logic                  w_owner_req;
    logic                  w_beat;
    logic                  w_final;
    logic                  w_release;
    logic                  w_arb;
    logic [7:0]            w_cnt8;

    ahb_arb_select #(
        .MASTER_NUM (MASTER_NUM),
        .PRIOR_BIT  (PRIOR_BIT)
    ) u_select (
        .i_req    (hreq),
        .i_prior  (hprior),
        .i_mode   (arb_mode),
        .i_rr_ptr (r_rr_ptr),
        .o_win    (w_win),
        .o_valid  (w_win_vld)
    );

    assign w_owner_req = hreq[r_owner];
    assign w_beat      = hsel & htrans[1] & ~hwait;
    assign w_cnt8      = 8'(r_cnt);
    assign w_release   = (r_state == ST_OWN) & ~w_owner_req & (htrans == 2'b00);
    // Final beat, owner release or an empty bus all open the same single arbitration slot.
    assign w_arb       = (r_state == ST_IDLE) | w_final | w_release;

    // Decode the one-hot winner back into an index for hmaster and rr_ptr.
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (w_win[i]) w_win_idx = IW'(i);
        end
    end

    // Final-beat detection; BUSY and waited beats never qualify since w_beat is low.
    always_comb begin
        w_final = 1'b0;
        if (w_beat) begin
            case (hburst)
                SINGLE:         w_final = 1'b1;
                INCR:           w_final = ~w_owner_req | (w_cnt8 == 8'(MAX_INCR_BEATS - 1));
                WRAP4, INCR4:   w_final = (w_cnt8 == BEATS_4);
                WRAP8, INCR8:   w_final = (w_cnt8 == BEATS_8);
                WRAP16, INCR16: w_final = (w_cnt8 == BEATS_16);
                default:        w_final = 1'b0;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // FSM next state: at an arbitration point go to OWN if anyone wins, else IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_arb) w_state_nxt = w_win_vld ? ST_OWN : ST_IDLE;
    end

    // Grant, owner, beat counter and rr_ptr; a re-grant to the same master clears the count.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_grant  <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= IW'(MASTER_NUM - 1);
        end else if (w_arb) begin
            if (w_win_vld) begin
                r_grant  <= w_win;
                r_owner  <= w_win_idx;
                r_cnt    <= '0;
                r_rr_ptr <= w_win_idx;
            end else begin
                r_grant  <= '0;
            end
        end else if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hgrant  = r_grant;
    assign hsel    = |r_grant;
    assign hmaster = r_owner;
    assign hlast   = w_final;

endmodule

// File: tb/tb_ahb_slave_arbiter_mm.sv
// Directed vector bench for ahb_slave_arbiter_mm (4 masters, 2-bit priority, INCR cap 16).
module tb_ahb_slave_arbiter_mm;
    import AHB_package::*;

    localparam logic [1:0] M_FIX = 2'b00, M_RR = 2'b01, M_DYN = 2'b10, M_X = 2'b11;
    localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [7:0] PR_0   = 8'h00;
    localparam logic [7:0] PR_DYN = 8'b11_01_11_00;
    localparam logic [7:0] PR_W8  = 8'b00_11_00_00;

    typedef struct {
        logic [3:0]      req;
        logic [3:0][1:0] prior;
        logic [1:0]      mode;
        hburst_type      burst;
        logic [1:0]      trans;
        logic            wt;
        logic [3:0]      e_grant;
        logic [1:0]      e_master;
        logic            e_last;
    } vec_t;

    logic            hclk = 1'b0;
    logic            hreset_n;
    logic [3:0]      hreq;
    logic [3:0][1:0] hprior;
    logic [1:0]      arb_mode;
    hburst_type      hburst;
    logic [1:0]      htrans;
    logic            hwait;
    logic [3:0]      hgrant;
    logic            hsel;
    logic [1:0]      hmaster;
    logic            hlast;

    int n_chk = 0;
    int n_err = 0;

    ahb_slave_arbiter_mm #(
        .MASTER_NUM     (4),
        .PRIOR_BIT      (2),
        .MAX_INCR_BEATS (16)
    ) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .hreq     (hreq),
        .hprior   (hprior),
        .arb_mode (arb_mode),
        .hburst   (hburst),
        .htrans   (htrans),
        .hwait    (hwait),
        .hgrant   (hgrant),
        .hsel     (hsel),
        .hmaster  (hmaster),
        .hlast    (hlast)
    );

    always #5 hclk = ~hclk;

    function automatic vec_t mk(input logic [3:0] req, input logic [7:0] pr, input logic [1:0] md,
                                input hburst_type bu, input logic [1:0] tr, input logic wt,
                                input logic [3:0] eg, input logic [1:0] em, input logic el);
        vec_t v;
        v.req = req; v.prior = pr; v.mode = md; v.burst = bu; v.trans = tr; v.wt = wt;
        v.e_grant = eg; v.e_master = em; v.e_last = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one vector, check outputs before the next rising edge, then step to the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        hreq = v.req; hprior = v.prior; arb_mode = v.mode;
        hburst = v.burst; htrans = v.trans; hwait = v.wt;
        #1;
        chk({tag, " hgrant"},  32'(hgrant),  32'(v.e_grant));
        chk({tag, " hsel"},    32'(hsel),    32'(|v.e_grant));
        chk({tag, " hmaster"}, 32'(hmaster), 32'(v.e_master));
        chk({tag, " hlast"},   32'(hlast),   32'(v.e_last));
        @(negedge hclk);
    endtask

    vec_t tbl[21];

    initial begin
        // Fixed: INCR4 by master 1, then handover to master 3, then release to idle.
        tbl[0]  = mk(4'b1010, PR_0,   M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd0, 1'b0);
        tbl[1]  = mk(4'b1010, PR_0,   M_FIX, INCR4,  T_NSEQ, 1'b0, 4'b0010, 2'd1, 1'b0);
        tbl[2]  = mk(4'b1010, PR_0,   M_FIX, INCR4,  T_SEQ,  1'b0, 4'b0010, 2'd1, 1'b0);
        tbl[3]  = mk(4'b1010, PR_0,   M_FIX, INCR4,  T_SEQ,  1'b0, 4'b0010, 2'd1, 1'b0);
        tbl[4]  = mk(4'b1000, PR_0,   M_FIX, INCR4,  T_SEQ,  1'b0, 4'b0010, 2'd1, 1'b1);
        tbl[5]  = mk(4'b1000, PR_0,   M_FIX, SINGLE, T_IDLE, 1'b0, 4'b1000, 2'd3, 1'b0);
        tbl[6]  = mk(4'b0000, PR_0,   M_FIX, SINGLE, T_IDLE, 1'b0, 4'b1000, 2'd3, 1'b0);
        tbl[7]  = mk(4'b0000, PR_0,   M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd3, 1'b0);
        // Round-robin rotation with SINGLE beats, no dead cycle between owners.
        tbl[8]  = mk(4'b1111, PR_0,   M_RR,  SINGLE, T_NSEQ, 1'b0, 4'b0000, 2'd3, 1'b0);
        tbl[9]  = mk(4'b1111, PR_0,   M_RR,  SINGLE, T_NSEQ, 1'b0, 4'b0001, 2'd0, 1'b1);
        tbl[10] = mk(4'b1111, PR_0,   M_RR,  SINGLE, T_NSEQ, 1'b0, 4'b0010, 2'd1, 1'b1);
        tbl[11] = mk(4'b1111, PR_0,   M_RR,  SINGLE, T_NSEQ, 1'b0, 4'b0100, 2'd2, 1'b1);
        tbl[12] = mk(4'b1111, PR_0,   M_RR,  SINGLE, T_NSEQ, 1'b0, 4'b1000, 2'd3, 1'b1);
        tbl[13] = mk(4'b1111, PR_0,   M_RR,  SINGLE, T_NSEQ, 1'b0, 4'b0001, 2'd0, 1'b1);
        tbl[14] = mk(4'b0000, PR_0,   M_RR,  SINGLE, T_IDLE, 1'b0, 4'b0010, 2'd1, 1'b0);
        tbl[15] = mk(4'b0000, PR_0,   M_RR,  SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd1, 1'b0);
        // Dynamic priority tie -> master 1; mode 11 behaves as fixed at the release point.
        tbl[16] = mk(4'b1111, PR_DYN, M_DYN, SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd1, 1'b0);
        tbl[17] = mk(4'b1111, PR_DYN, M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0010, 2'd1, 1'b0);
        tbl[18] = mk(4'b1101, PR_DYN, M_X,   SINGLE, T_IDLE, 1'b0, 4'b0010, 2'd1, 1'b0);
        tbl[19] = mk(4'b0000, PR_0,   M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0001, 2'd0, 1'b0);
        tbl[20] = mk(4'b0000, PR_0,   M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd0, 1'b0);

        // Reset: outputs stay zero across edges even with requests pending.
        hreset_n = 1'b0;
        hreq = 4'b1111; hprior = PR_0; arb_mode = M_FIX;
        hburst = SINGLE; htrans = T_NSEQ; hwait = 1'b0;
        @(negedge hclk); @(negedge hclk); #1;
        chk("reset hgrant",  32'(hgrant),  32'h0);
        chk("reset hsel",    32'(hsel),    32'h0);
        chk("reset hmaster", 32'(hmaster), 32'h0);
        chk("reset hlast",   32'(hlast),   32'h0);
        hreset_n = 1'b1;
        hreq = 4'b0000; htrans = T_IDLE;
        @(negedge hclk);

        for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // WRAP8 owned by master 2 (won in dynamic mode), mode flipped mid-burst,
        // hwait held on beat 8, master 0 requesting throughout.
        apply(mk(4'b0101, PR_W8, M_DYN, SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd0, 1'b0), "w8 arb");
        for (int b = 1; b <= 7; b++)
            apply(mk(4'b0101, PR_W8, M_FIX, WRAP8, (b == 1) ? T_NSEQ : T_SEQ, 1'b0,
                     4'b0100, 2'd2, 1'b0), $sformatf("w8 beat%0d", b));
        apply(mk(4'b0101, PR_W8, M_FIX, WRAP8, T_SEQ, 1'b1, 4'b0100, 2'd2, 1'b0), "w8 wait1");
        apply(mk(4'b0101, PR_W8, M_FIX, WRAP8, T_SEQ, 1'b1, 4'b0100, 2'd2, 1'b0), "w8 wait2");
        apply(mk(4'b0101, PR_W8, M_FIX, WRAP8, T_SEQ, 1'b0, 4'b0100, 2'd2, 1'b1), "w8 beat8");
        apply(mk(4'b0101, PR_W8, M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0001, 2'd0, 1'b0), "w8 handover");
        apply(mk(4'b0000, PR_0, M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0001, 2'd0, 1'b0), "w8 release");
        apply(mk(4'b0000, PR_0, M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd0, 1'b0), "w8 idle");

        // INCR held by master 1: forced release at beat 16; master 0 arrives on that beat.
        apply(mk(4'b0010, PR_0, M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd0, 1'b0), "cap arb");
        for (int b = 1; b <= 16; b++)
            apply(mk((b == 16) ? 4'b0011 : 4'b0010, PR_0, M_FIX, INCR,
                     (b == 1) ? T_NSEQ : T_SEQ, 1'b0, 4'b0010, 2'd1, (b == 16)),
                  $sformatf("cap beat%0d", b));
        // INCR by master 0 with its request dropped on beat 5.
        for (int b = 1; b <= 5; b++)
            apply(mk((b == 5) ? 4'b0010 : 4'b0001, PR_0, M_FIX, INCR,
                     (b == 1) ? T_NSEQ : T_SEQ, 1'b0, 4'b0001, 2'd0, (b == 5)),
                  $sformatf("drop beat%0d", b));
        apply(mk(4'b0010, PR_0, M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0010, 2'd1, 1'b0), "drop handover");
        apply(mk(4'b0000, PR_0, M_FIX, SINGLE, T_IDLE, 1'b0, 4'b0010, 2'd1, 1'b0), "drop release");

        // Reset mid INCR16 in round-robin: immediate clear, then master 0 wins first.
        apply(mk(4'b0100, PR_0, M_RR, SINGLE, T_IDLE, 1'b0, 4'b0000, 2'd1, 1'b0), "rst arb");
        apply(mk(4'b0100, PR_0, M_RR, INCR16, T_NSEQ, 1'b0, 4'b0100, 2'd2, 1'b0), "rst beat1");
        apply(mk(4'b0100, PR_0, M_RR, INCR16, T_SEQ,  1'b0, 4'b0100, 2'd2, 1'b0), "rst beat2");
        #2 hreset_n = 1'b0;
        #1;
        chk("async rst hgrant",  32'(hgrant),  32'h0);
        chk("async rst hsel",    32'(hsel),    32'h0);
        chk("async rst hmaster", 32'(hmaster), 32'h0);
        chk("async rst hlast",   32'(hlast),   32'h0);
        @(negedge hclk);
        hreset_n = 1'b1;
        apply(mk(4'b1111, PR_0, M_RR, SINGLE, T_NSEQ, 1'b0, 4'b0000, 2'd0, 1'b0), "post rst arb");
        apply(mk(4'b1111, PR_0, M_RR, SINGLE, T_NSEQ, 1'b0, 4'b0001, 2'd0, 1'b1), "post rst grant");
        apply(mk(4'b0000, PR_0, M_RR, SINGLE, T_IDLE, 1'b0, 4'b0010, 2'd1, 1'b0), "post rst next");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
